// File: rtl/rconv_pkg.sv
// Shared types and constants for the convolution front-end: scheduler states,
// legal patch sizes and the row batching used to split row_idx into cycle_counts/k.
package rconv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CFG,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int ROWS_PER_BATCH = 8;
    localparam int ROW_SHIFT      = $clog2(ROWS_PER_BATCH);

    localparam logic [2:0] PATCH_LEGAL [3] = '{3'd3, 3'd5, 3'd7};

    function automatic logic patch_legal(input logic [2:0] p);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (p == PATCH_LEGAL[i]) ok = 1'b1;
        end
        return ok;
    endfunction

    // Coordinate width able to hold 0..n inclusive.
    function automatic int coord_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/patch_scheduler_axis_stepper.sv
// One sweep axis: advances a patch coordinate by stride and flags when the next
// step would pass the last legal origin, in which case the coordinate wraps to 0.
module axis_stepper
    import rconv_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0] pos,
    input  logic [W-1:0] lim,
    input  logic [2:0]   stride,
    input  logic         step,
    input  logic         clear,
    output logic [W-1:0] pos_next,
    output logic         wrap
);

    // One bit wider than the coordinate so pos+stride can never alias.
    logic [W:0] sum;

    assign sum  = {1'b0, pos} + (W+1)'(stride);
    assign wrap = sum > {1'b0, lim};

    always_comb begin
        pos_next = pos;
        if (clear) begin
            pos_next = '0;
        end else if (step) begin
            pos_next = wrap ? '0 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/patch_scheduler.sv
// Sweeps every legal patch origin of a latched convolution config in row-major
// order and hands each position to addr_gen over a valid/ready handshake.
module patch_scheduler
    import rconv_pkg::*;
#(
    parameter int  WIDTH  = 32,
    parameter int  HEIGHT = 32,
    localparam int CW     = coord_w(WIDTH),
    localparam int CH     = coord_w(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [2:0]    patch_size,
    input  logic [2:0]    stride,
    input  logic [CW-1:0] image_width,
    input  logic [CH-1:0] image_height,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [CW-1:0] xcor,
    output logic [CH-1:0] ycor,
    output logic [5:0]    cycle_counts,
    output logic [2:0]    k,
    output logic          last_in_row,
    output logic          last,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    state_t        state, state_next;
    logic [2:0]    patch_q, stride_q;
    logic [CW-1:0] width_q, xlim_q, x_q, x_next;
    logic [CH-1:0] height_q, ylim_q, y_q, y_next, row_q;
    logic          x_wrap, y_wrap;
    logic          cfg_bad, accept, run_clear;

    assign cfg_bad = !patch_legal(patch_q) || (stride_q == 3'd0) ||
                     (CW'(patch_q) > width_q) || (CH'(patch_q) > height_q);

    assign accept    = (state == ST_RUN) && out_ready && !abort;
    assign run_clear = (state == ST_CFG);

    axis_stepper #(.W(CW)) u_x_step (
        .pos      (x_q),
        .lim      (xlim_q),
        .stride   (stride_q),
        .step     (accept),
        .clear    (run_clear),
        .pos_next (x_next),
        .wrap     (x_wrap)
    );

    // y only moves when x has run off the end of its row.
    axis_stepper #(.W(CH)) u_y_step (
        .pos      (y_q),
        .lim      (ylim_q),
        .stride   (stride_q),
        .step     (accept && x_wrap),
        .clear    (run_clear),
        .pos_next (y_next),
        .wrap     (y_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            patch_q  <= '0;
            stride_q <= '0;
            width_q  <= '0;
            height_q <= '0;
            xlim_q   <= '0;
            ylim_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            row_q    <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start && !abort) begin
                patch_q  <= patch_size;
                stride_q <= stride;
                width_q  <= image_width;
                height_q <= image_height;
            end
            if (state == ST_CFG) begin
                xlim_q <= width_q - CW'(patch_q);
                ylim_q <= height_q - CH'(patch_q);
                row_q  <= '0;
            end else if (accept && x_wrap && !y_wrap) begin
                row_q <= row_q + 1'b1;
            end
            x_q <= x_next;
            y_q <= y_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cfg_err    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_CFG;
            end
            ST_CFG: begin
                busy       = 1'b1;
                cfg_err    = cfg_bad;
                state_next = cfg_bad ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (accept && x_wrap && y_wrap) state_next = ST_DONE;
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) state_next = ST_IDLE;
    end

    // Position fields are forced to zero whenever no beat is being offered.
    assign xcor         = out_valid ? CW'(x_q + 1'b1) : '0;
    assign ycor         = out_valid ? y_q : '0;
    assign cycle_counts = out_valid ? 6'((row_q >> ROW_SHIFT) + 1'b1) : '0;
    assign k            = out_valid ? row_q[ROW_SHIFT-1:0] : '0;
    assign last_in_row  = out_valid && x_wrap;
    assign last         = out_valid && x_wrap && y_wrap;

endmodule

// File: tb/tb_patch_scheduler.sv
// Directed bench for patch_scheduler: full sweeps, back-pressure, rejected
// configs, single-position frames and abort/reset recovery.
module tb_patch_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, abort, out_ready;
    logic [2:0] patch_size, stride;
    logic [5:0] image_width, image_height;
    logic       out_valid, last_in_row, last, busy, done, cfg_err;
    logic [5:0] xcor, ycor, cycle_counts;
    logic [2:0] k;

    int vectors     = 0;
    int miscompares = 0;

    patch_scheduler #(.WIDTH(32), .HEIGHT(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .patch_size   (patch_size),
        .stride       (stride),
        .image_width  (image_width),
        .image_height (image_height),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .xcor         (xcor),
        .ycor         (ycor),
        .cycle_counts (cycle_counts),
        .k            (k),
        .last_in_row  (last_in_row),
        .last         (last),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "/out_valid"}, out_valid, 0);
        chk({tag, "/xcor"},      xcor, 0);
        chk({tag, "/busy"},      busy, 0);
        chk({tag, "/done"},      done, 0);
        chk({tag, "/cfg_err"},   cfg_err, 0);
    endtask

    task automatic check_beat(input string tag, input int x, input int y, input int row,
                              input bit lir, input bit lst);
        chk({tag, "/out_valid"},    out_valid, 1);
        chk({tag, "/busy"},         busy, 1);
        chk({tag, "/xcor"},         xcor, x + 1);
        chk({tag, "/ycor"},         ycor, y);
        chk({tag, "/k"},            k, row % 8);
        chk({tag, "/cycle_counts"}, cycle_counts, 1 + row / 8);
        chk({tag, "/last_in_row"},  last_in_row, lir);
        chk({tag, "/last"},         last, lst);
        chk({tag, "/done"},         done, 0);
    endtask

    task automatic apply_cfg(input int ps, input int st, input int w, input int h);
        patch_size   = 3'(ps);
        stride       = 3'(st);
        image_width  = 6'(w);
        image_height = 6'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input int ps, input int st, input int w, input int h,
                             input bit stall, input string tag);
        int row;
        bit lir, lst;
        row = 0;
        out_ready = 1'b1;
        apply_cfg(ps, st, w, h);
        chk({tag, "/cfg_busy"},  busy, 1);
        chk({tag, "/cfg_err"},   cfg_err, 0);
        chk({tag, "/cfg_valid"}, out_valid, 0);
        tick();
        for (int y = 0; y <= h - ps; y += st) begin
            for (int x = 0; x <= w - ps; x += st) begin
                lir = (x + st > w - ps);
                lst = lir && (y + st > h - ps);
                check_beat(tag, x, y, row, lir, lst);
                if (stall) begin
                    out_ready = 1'b0;
                    tick();
                    check_beat({tag, "/stall1"}, x, y, row, lir, lst);
                    tick();
                    check_beat({tag, "/stall2"}, x, y, row, lir, lst);
                    out_ready = 1'b1;
                end
                tick();
            end
            row++;
        end
        chk({tag, "/done"},      done, 1);
        chk({tag, "/done_busy"}, busy, 1);
        chk({tag, "/done_vld"},  out_valid, 0);
        chk({tag, "/done_xcor"}, xcor, 0);
        tick();
        check_idle({tag, "/after"});
    endtask

    task automatic cfg_reject(input int ps, input int st, input int w, input int h,
                              input string tag);
        out_ready = 1'b1;
        apply_cfg(ps, st, w, h);
        chk({tag, "/cfg_err"},   cfg_err, 1);
        chk({tag, "/out_valid"}, out_valid, 0);
        chk({tag, "/busy"},      busy, 1);
        tick();
        check_idle({tag, "/post1"});
        tick();
        check_idle({tag, "/post2"});
    endtask

    initial begin
        int ax[4];
        int ay[4];
        ax = '{1, 3, 5, 1};
        ay = '{0, 0, 0, 2};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        patch_size = '0; stride = '0; image_width = '0; image_height = '0;
        tick();
        tick();
        check_idle("reset");
        chk("reset/ycor",         ycor, 0);
        chk("reset/cycle_counts", cycle_counts, 0);
        chk("reset/k",            k, 0);
        chk("reset/last",         last, 0);
        chk("reset/last_in_row",  last_in_row, 0);
        rst = 1'b0;
        tick();
        check_idle("idle");

        // Basic sweep, then the same sweep under 1-of-3 back-pressure.
        run_frame(3, 2, 8, 8, 1'b0, "t1");
        run_frame(3, 2, 8, 8, 1'b1, "t2");

        // 9x9 origins; row 8 moves into the second batch.
        run_frame(7, 3, 32, 32, 1'b0, "t3");

        cfg_reject(4, 1, 8, 8, "t4_p4");
        cfg_reject(5, 1, 4, 8, "t4_w4");
        cfg_reject(3, 0, 8, 8, "t4_s0");
        cfg_reject(5, 1, 8, 4, "t4_h4");

        // Image equals patch: one beat.
        run_frame(5, 1, 5, 5, 1'b0, "t5");

        // Abort mid-frame, then restart.
        out_ready = 1'b1;
        apply_cfg(3, 2, 8, 8);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t6a/xcor", xcor, ax[i]);
            chk("t6a/ycor", ycor, ay[i]);
            tick();
        end
        chk("t6a/beat5_xcor", xcor, 3);
        chk("t6a/beat5_ycor", ycor, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("t6a/aborted");
        tick();
        check_idle("t6a/aborted2");
        run_frame(3, 2, 8, 8, 1'b0, "t6a_restart");

        // Same with reset instead of abort.
        apply_cfg(3, 2, 8, 8);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t6r/xcor", xcor, ax[i]);
            chk("t6r/ycor", ycor, ay[i]);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("t6r/reset");
        tick();
        check_idle("t6r/reset2");
        run_frame(3, 2, 8, 8, 1'b0, "t6r_restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
